// File: rtl/flow_vga_pkg.sv
// Shared constants and state encoding for the flow core's VGA-side raster blocks.
// Screen geometry matches the 160x120, 15-bit colour vga_adapter.
package flow_vga_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int COLOR_W  = 15;

    localparam int X_W = 8;
    localparam int Y_W = 7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        FINISH = 2'd2
    } fill_state_t;

endpackage

// File: rtl/rect_scan_counter.sv
// Nested column/row scan counter for rectangle fills: cx is the inner loop, cy the outer.
// Exposes the post-edge counter values so the caller can register the matching pixel.
module rect_scan_counter
    import flow_vga_pkg::*;
(
    input  logic           clock,
    input  logic           reset,
    input  logic           load,
    input  logic           advance,
    input  logic [X_W-1:0] w,
    input  logic [Y_W-1:0] h,
    output logic [X_W-1:0] cx_nxt,
    output logic [Y_W-1:0] cy_nxt,
    output logic           last
);

    localparam logic [X_W-1:0] ONE_X = 1;
    localparam logic [Y_W-1:0] ONE_Y = 1;

    logic [X_W-1:0] cx;
    logic [Y_W-1:0] cy;
    logic           row_end;

    assign row_end = (cx == w - ONE_X);
    assign last    = row_end && (cy == h - ONE_Y);

    always_comb begin
        cx_nxt = cx;
        cy_nxt = cy;
        if (load) begin
            cx_nxt = '0;
            cy_nxt = '0;
        end else if (advance) begin
            if (row_end) begin
                cx_nxt = '0;
                cy_nxt = cy + ONE_Y;
            end else begin
                cx_nxt = cx + ONE_X;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cx <= '0;
            cy <= '0;
        end else begin
            cx <= cx_nxt;
            cy <= cy_nxt;
        end
    end

endmodule

// File: rtl/flow_rect_fill.sv
// Rectangle-fill raster engine: one command per handshake, one registered pixel per clock
// in raster order toward vga_adapter, with off-screen pixels clipped (plot held low).
module flow_rect_fill
    import flow_vga_pkg::*;
#(
    parameter int SCREEN_W = flow_vga_pkg::SCREEN_W,
    parameter int SCREEN_H = flow_vga_pkg::SCREEN_H,
    parameter int COLOR_W  = flow_vga_pkg::COLOR_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [X_W-1:0]     cmd_x,
    input  logic [Y_W-1:0]     cmd_y,
    input  logic [X_W-1:0]     cmd_w,
    input  logic [Y_W-1:0]     cmd_h,
    input  logic [COLOR_W-1:0] cmd_color,
    output logic [X_W-1:0]     vga_x,
    output logic [Y_W-1:0]     vga_y,
    output logic [COLOR_W-1:0] vga_color,
    output logic               vga_plot,
    output logic               busy,
    output logic               done
);

    fill_state_t        state, state_nxt;

    logic [X_W-1:0]     lat_x, lat_w;
    logic [Y_W-1:0]     lat_y, lat_h;
    logic [COLOR_W-1:0] lat_color;

    logic [X_W-1:0]     cx_nxt;
    logic [Y_W-1:0]     cy_nxt;
    logic               last;
    logic               accept, advance, empty_cmd;

    logic [X_W:0]       px_p0;
    logic [Y_W:0]       py_p0;
    logic [COLOR_W-1:0] color_p0;
    logic               inside_p0;

    logic               ready_nxt, done_nxt, vld_nxt, load_pix;
    logic               ready_p1, done_p1, vld_p1;
    logic [X_W-1:0]     pix_x_p1;
    logic [Y_W-1:0]     pix_y_p1;
    logic [COLOR_W-1:0] color_p1;

    assign accept    = cmd_valid && ready_p1;
    assign advance   = (state == FILL) && !last;
    assign empty_cmd = (cmd_w == '0) || (cmd_h == '0);

    rect_scan_counter u_scan (
        .clock   (clock),
        .reset   (reset),
        .load    (accept),
        .advance (advance),
        .w       (lat_w),
        .h       (lat_h),
        .cx_nxt  (cx_nxt),
        .cy_nxt  (cy_nxt),
        .last    (last)
    );

    // Stage 0: position of the pixel that will be on the outputs after this edge.
    // On the accepting edge the counter loads zero, so the raw command origin is used.
    assign px_p0     = {1'b0, (accept ? cmd_x : lat_x)} + {1'b0, cx_nxt};
    assign py_p0     = {1'b0, (accept ? cmd_y : lat_y)} + {1'b0, cy_nxt};
    assign color_p0  = accept ? cmd_color : lat_color;
    assign inside_p0 = (px_p0 < (X_W+1)'(SCREEN_W)) && (py_p0 < (Y_W+1)'(SCREEN_H));

    always_comb begin
        state_nxt = state;
        ready_nxt = 1'b0;
        done_nxt  = 1'b0;
        vld_nxt   = 1'b0;
        load_pix  = 1'b0;
        unique case (state)
            IDLE: begin
                ready_nxt = 1'b1;
                if (accept) begin
                    ready_nxt = 1'b0;
                    load_pix  = 1'b1;
                    if (empty_cmd) begin
                        state_nxt = FINISH;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = FILL;
                        vld_nxt   = inside_p0;
                    end
                end
            end
            FILL: begin
                if (last) begin
                    state_nxt = FINISH;
                    done_nxt  = 1'b1;
                end else begin
                    load_pix = 1'b1;
                    vld_nxt  = inside_p0;
                end
            end
            FINISH: begin
                state_nxt = IDLE;
                ready_nxt = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
                ready_nxt = 1'b1;
            end
        endcase
    end

    // Stage 1: registered adapter outputs; reset clears them so no stale pixel survives an abort.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            ready_p1 <= 1'b1;
            done_p1  <= 1'b0;
            vld_p1   <= 1'b0;
            pix_x_p1 <= '0;
            pix_y_p1 <= '0;
            color_p1 <= '0;
        end else begin
            state    <= state_nxt;
            ready_p1 <= ready_nxt;
            done_p1  <= done_nxt;
            vld_p1   <= vld_nxt;
            if (load_pix) begin
                pix_x_p1 <= px_p0[X_W-1:0];
                pix_y_p1 <= py_p0[Y_W-1:0];
                color_p1 <= color_p0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            lat_x     <= cmd_x;
            lat_y     <= cmd_y;
            lat_w     <= cmd_w;
            lat_h     <= cmd_h;
            lat_color <= cmd_color;
        end
    end

    assign cmd_ready = ready_p1;
    assign busy      = ~ready_p1;
    assign done      = done_p1;
    assign vga_plot  = vld_p1;
    assign vga_x     = pix_x_p1;
    assign vga_y     = pix_y_p1;
    assign vga_color = color_p1;

endmodule

// File: tb/tb_flow_rect_fill.sv
// Self-checking bench for flow_rect_fill: directed fills, clipping, empty commands,
// mid-fill reset, ignored inputs while busy, and randomized rectangles against a raster model.
module tb_flow_rect_fill;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    logic        clock;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_x;
    logic [6:0]  cmd_y;
    logic [7:0]  cmd_w;
    logic [6:0]  cmd_h;
    logic [14:0] cmd_color;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [14:0] vga_color;
    logic        vga_plot;
    logic        busy;
    logic        done;

    int tests_run = 0;
    int failed    = 0;

    flow_rect_fill dut (
        .clock     (clock),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .cmd_w     (cmd_w),
        .cmd_h     (cmd_h),
        .cmd_color (cmd_color),
        .vga_x     (vga_x),
        .vga_y     (vga_y),
        .vga_color (vga_color),
        .vga_plot  (vga_plot),
        .busy      (busy),
        .done      (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    // Advance to just after the next rising edge; outputs are stable and inputs may change.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cmd_valid = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tests_run++;
            if ({cmd_ready, busy, vga_plot, done, vga_x, vga_y, vga_color} !==
                {1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 7'd0, 15'd0}) begin
                failed++;
                $display("FAIL reset_idle[%0d]: rdy=%b busy=%b plot=%b done=%b x=%0d y=%0d col=%h required rdy=1 busy=0 plot=0 done=0 x=0 y=0 col=0",
                         i, cmd_ready, busy, vga_plot, done, vga_x, vga_y, vga_color);
            end
            step();
        end
    endtask

    // Issues one command and compares every cycle against the raster model.
    // With scramble set, cmd_valid stays high and cmd_* change every busy cycle.
    task automatic test_fill(input string name, input int x, input int y, input int w,
                             input int h, input logic [14:0] c, input bit scramble);
        int waits;
        int px;
        int py;
        logic exp_plot;
        waits = 0;
        while (cmd_ready !== 1'b1 && waits < 16) begin
            step();
            waits++;
        end
        tests_run++;
        if (cmd_ready !== 1'b1) begin
            failed++;
            $display("FAIL %s ready_wait: cmd_ready=%b required 1", name, cmd_ready);
            return;
        end
        cmd_x = 8'(x);
        cmd_y = 7'(y);
        cmd_w = 8'(w);
        cmd_h = 7'(h);
        cmd_color = c;
        cmd_valid = 1'b1;
        step();
        if (!scramble) cmd_valid = 1'b0;
        for (int r = 0; r < h; r++) begin
            for (int col = 0; col < w; col++) begin
                px = x + col;
                py = y + r;
                exp_plot = (px < SCREEN_W) && (py < SCREEN_H);
                tests_run++;
                if ({vga_plot, vga_x, vga_y, vga_color, done, cmd_ready, busy} !==
                    {exp_plot, 8'(px), 7'(py), c, 1'b0, 1'b0, 1'b1}) begin
                    failed++;
                    $display("FAIL %s pix(%0d,%0d): plot=%b x=%0d y=%0d col=%h done=%b rdy=%b busy=%b required plot=%b x=%0d y=%0d col=%h done=0 rdy=0 busy=1",
                             name, col, r, vga_plot, vga_x, vga_y, vga_color, done, cmd_ready, busy,
                             exp_plot, px % 256, py % 128, c);
                end
                if (scramble) begin
                    cmd_x = 8'($urandom);
                    cmd_y = 7'($urandom);
                    cmd_w = 8'($urandom);
                    cmd_h = 7'($urandom);
                    cmd_color = 15'($urandom);
                end
                step();
            end
        end
        cmd_valid = 1'b0;
        tests_run++;
        if ({done, vga_plot, cmd_ready} !== 3'b100) begin
            failed++;
            $display("FAIL %s finish: done=%b plot=%b rdy=%b required done=1 plot=0 rdy=0",
                     name, done, vga_plot, cmd_ready);
        end
        step();
        tests_run++;
        if ({done, vga_plot, cmd_ready} !== 3'b001) begin
            failed++;
            $display("FAIL %s ready_back: done=%b plot=%b rdy=%b required done=0 plot=0 rdy=1",
                     name, done, vga_plot, cmd_ready);
        end
    endtask

    task automatic test_empty_then_held();
        cmd_x = 8'd50;
        cmd_y = 7'd50;
        cmd_w = 8'd0;
        cmd_h = 7'd5;
        cmd_color = 15'h03E0;
        cmd_valid = 1'b1;
        step();
        // cycle N+1: second command presented and held
        cmd_x = 8'd5;
        cmd_y = 7'd6;
        cmd_w = 8'd2;
        cmd_h = 7'd1;
        cmd_color = 15'h001F;
        tests_run++;
        if ({done, vga_plot, cmd_ready} !== 3'b100) begin
            failed++;
            $display("FAIL empty_done: done=%b plot=%b rdy=%b required done=1 plot=0 rdy=0",
                     done, vga_plot, cmd_ready);
        end
        step();
        tests_run++;
        if ({done, vga_plot, cmd_ready} !== 3'b001) begin
            failed++;
            $display("FAIL empty_ready: done=%b plot=%b rdy=%b required done=0 plot=0 rdy=1",
                     done, vga_plot, cmd_ready);
        end
        step();
        cmd_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tests_run++;
            if ({vga_plot, vga_x, vga_y, vga_color, cmd_ready} !== {1'b1, 8'(5 + k), 7'd6, 15'h001F, 1'b0}) begin
                failed++;
                $display("FAIL held_pix%0d: plot=%b x=%0d y=%0d col=%h rdy=%b required plot=1 x=%0d y=6 col=001f rdy=0",
                         k, vga_plot, vga_x, vga_y, vga_color, cmd_ready, 5 + k);
            end
            step();
        end
        tests_run++;
        if ({done, vga_plot} !== 2'b10) begin
            failed++;
            $display("FAIL held_done: done=%b plot=%b required done=1 plot=0", done, vga_plot);
        end
        step();
    endtask

    task automatic test_reset_midfill();
        int done_seen;
        cmd_x = 8'd0;
        cmd_y = 7'd0;
        cmd_w = 8'd100;
        cmd_h = 7'd100;
        cmd_color = 15'h5555;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        repeat (50) step();
        tests_run++;
        if ({vga_plot, vga_x, vga_y, vga_color} !== {1'b1, 8'd50, 7'd0, 15'h5555}) begin
            failed++;
            $display("FAIL midfill_pix50: plot=%b x=%0d y=%0d col=%h required plot=1 x=50 y=0 col=5555",
                     vga_plot, vga_x, vga_y, vga_color);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        tests_run++;
        if ({vga_plot, cmd_ready, done, vga_x, vga_y, vga_color} !==
            {1'b0, 1'b1, 1'b0, 8'd0, 7'd0, 15'd0}) begin
            failed++;
            $display("FAIL midfill_reset: plot=%b rdy=%b done=%b x=%0d y=%0d col=%h required plot=0 rdy=1 done=0 x=0 y=0 col=0",
                     vga_plot, cmd_ready, done, vga_x, vga_y, vga_color);
        end
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (done === 1'b1 || vga_plot === 1'b1) done_seen++;
            step();
        end
        tests_run++;
        if (done_seen != 0) begin
            failed++;
            $display("FAIL midfill_no_done: activity cycles=%0d required 0", done_seen);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            int x;
            int y;
            int w;
            int h;
            x = (i % 3 == 0) ? int'($urandom_range(140, 255)) : int'($urandom_range(0, 159));
            y = (i % 3 == 1) ? int'($urandom_range(100, 127)) : int'($urandom_range(0, 119));
            w = int'($urandom_range(0, 20));
            h = int'($urandom_range(0, 10));
            test_fill("random", x, y, w, h, 15'($urandom), 1'b0);
        end
    endtask

    initial begin
        reset = 1'b0;
        cmd_valid = 1'b0;
        cmd_x = '0;
        cmd_y = '0;
        cmd_w = '0;
        cmd_h = '0;
        cmd_color = '0;
        test_reset();
        test_fill("basic", 10, 20, 3, 2, 15'h7C00, 1'b0);
        test_fill("clip", 158, 119, 4, 2, 15'h1234, 1'b0);
        test_empty_then_held();
        test_reset_midfill();
        test_fill("after_reset", 3, 4, 5, 3, 15'h2A5A, 1'b0);
        test_fill("ignore", 30, 40, 7, 4, 15'h6B21, 1'b1);
        test_fill("single", 159, 119, 1, 1, 15'h7FFF, 1'b0);
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
